// File: rtl/cska_serial_adder.sv
// cska_serial_adder: multi-cycle carry-skip adder, one BLK-bit slice per clock.
// Operands are accepted over a valid/ready handshake. The slices are then
// sequenced through a single carry register, and the finished sum is held
// until the consumer takes it.
// Optional build macro: CSKA_SKIP_STATS_EN keeps the skip_count statistics
// counter. When the macro is undefined, skip_count is tied to 0.
//
// Handshake semantics: a transfer happens on a rising clk edge where
// valid && ready are both 1. in_ready is 1 only in IDLE, and out_valid is 1
// only in DONE, so the input and output transfers can never coincide.
module cska_serial_adder #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  a,
    input  logic [WIDTH-1:0]                  b,
    input  logic                              cin,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  sum,
    output logic                              cout,
    output logic [$clog2(WIDTH/BLK+1)-1:0]    skip_count
);

    localparam int NBLK = WIDTH / BLK;
    localparam int IW   = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int SW   = $clog2(NBLK + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [BLK-1:0]   slice_a;
    logic [BLK-1:0]   slice_b;
    logic [BLK-1:0]   p;
    logic [BLK-1:0]   g;
    logic [BLK:0]     c;
    logic [BLK-1:0]   slice_sum;
    logic             p_block;
    logic             block_cout;
    logic             last_slice;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign sum        = sum_q;
    assign cout       = cout_q;
    assign last_slice = (idx == IW'(NBLK - 1));

    // Current slice: ripple the carry through the block. When every bit
    // propagates, take the carry-out straight from carry_q (the skip path).
    always_comb begin
        slice_a = BLK'(a_q >> (idx * BLK));
        slice_b = BLK'(b_q >> (idx * BLK));
        p       = slice_a ^ slice_b;
        g       = slice_a & slice_b;
        c       = '0;
        c[0]    = carry_q;
        for (int i = 0; i < BLK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        slice_sum  = p ^ c[BLK-1:0];
        p_block    = &p;
        block_cout = p_block ? carry_q : c[BLK];
    end

    // Sequencer, operand capture, carry chain and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx     <= '0;
                        sum_q   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx*BLK +: BLK] <= slice_sum;
                    carry_q               <= block_cout;
                    if (last_slice) begin
                        cout_q <= block_cout;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CSKA_SKIP_STATS_EN
    logic [SW-1:0] skip_q;

    // Count the slices of the current add whose bits all propagate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_q <= '0;
        end else if (state == IDLE && in_valid) begin
            skip_q <= '0;
        end else if (state == RUN && p_block) begin
            skip_q <= skip_q + 1'b1;
        end
    end

    assign skip_count = skip_q;
`else
    assign skip_count = '0;
`endif

endmodule

// File: tb/tb_cska_serial_adder.sv
// Testbench for cska_serial_adder. It uses directed cases followed by random
// adds. Results are checked against an arithmetic reference model.
module tb_cska_serial_adder;

  localparam int WIDTH = 32;
  localparam int BLK   = 4;
  localparam int NBLK  = WIDTH / BLK;
  localparam int SW    = $clog2(NBLK + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [SW-1:0]    skip_count;

  int n_cmp;
  int n_fail;

  cska_serial_adder #(.WIDTH(WIDTH), .BLK(BLK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .cout       (cout),
    .skip_count (skip_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the sum is computed with plain arithmetic.
  function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] ma,
                                               input logic [WIDTH-1:0] mb,
                                               input logic mc);
    logic [WIDTH:0] r;
    r = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mc};
    return r;
  endfunction

  // Reference model: count the blocks whose operand bits all differ.
  function automatic int model_skip(input logic [WIDTH-1:0] ma,
                                    input logic [WIDTH-1:0] mb);
    int n;
    logic [WIDTH-1:0] x;
    n = 0;
    x = ma ^ mb;
    for (int i = 0; i < NBLK; i++) begin
      if (((x >> (i * BLK)) & ((1 << BLK) - 1)) == ((1 << BLK) - 1)) n++;
    end
`ifdef CSKA_SKIP_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: run one add with `stall` cycles of out_ready=0 in DONE.
  // With hammer=1, in_valid is held high with fresh operands during the stall.
  task automatic do_add(input string tag, input logic [WIDTH-1:0] ta,
                        input logic [WIDTH-1:0] tb_, input logic tc,
                        input int stall, input bit hammer, input bit full_checks);
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] exp_v;
    int             exp_skip;
    int             cycles;
    exp_q.push_back(model_sum(ta, tb_, tc));
    exp_skip = model_skip(ta, tb_);
    @(negedge clk);
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_ready: observed in_ready=0 expected 1", tag);
    end
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    exp_v = exp_q.pop_front();
    check({tag, "_latency"}, 64'(cycles), 64'(NBLK));
    check({tag, "_sum"}, 64'({cout, sum}), 64'(exp_v));
    check({tag, "_skip"}, 64'(skip_count), 64'(exp_skip));
    for (int s = 0; s < stall; s++) begin
      if (hammer) begin
        in_valid = 1'b1; a = $urandom; b = $urandom;
      end
      @(negedge clk);
      if (full_checks) begin
        check({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_stall_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_stall_sum"}, 64'({cout, sum}), 64'(exp_v));
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    if (full_checks) begin
      check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_post_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_post_hold"}, 64'({cout, sum}), 64'(exp_v));
      check({tag, "_post_skip"}, 64'(skip_count), 64'(exp_skip));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'({cout, sum}), 64'd0);
    check("rst_skip", 64'(skip_count), 64'd0);

    // directed cases
    do_add("small", 32'h0000_0001, 32'h0000_0002, 1'b0, 0, 1'b0, 1'b1);
    do_add("allprop", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 1'b0, 1'b1);
    do_add("msb", 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1'b0, 1'b1);
    do_add("backpress", 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 5, 1'b1, 1'b1);

    // Reset mid-operation: abort after three RUN slices.
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", 64'({cout, sum}), 64'd0);
    check("midrst_skip", 64'(skip_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_add("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1, 1'b0, 1'b1);

    // randomized adds with random output stalls
    for (int i = 0; i < 1000; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ~ra;
        1: rb = ~ra ^ (32'hF << (4 * $urandom_range(0, 7)));
        default: rb = $urandom;
      endcase
      do_add("rand", ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog: end the run with a FAIL line if the sequence ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
